// File: rtl/fir4_mac_datapath.sv
// 4-tap signed FIR multiply-accumulate datapath driven by an external tap sequencer.
// One tap is folded into the accumulator per cycle. At frame end the sum is rounded, saturated and registered.
module fir4_mac_datapath #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 34
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mux_sel,
  input  logic              clear_accum,
  input  logic              data_clk,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              coef_we,
  input  logic [1:0]        coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic signed [ACC_W:0] RND_HALF = (ACC_W+1)'(1) << (COEF_W-2);
  localparam logic signed [ACC_W:0] SAT_HI   = (ACC_W+1)'((64'sd1 <<< (DATA_W-1)) - 64'sd1);
  localparam logic signed [ACC_W:0] SAT_LO   = -SAT_HI - (ACC_W+1)'(1);

  // x[0] holds the newest sample; packed so the shift is a single concat
  logic [3:0][DATA_W-1:0] r_x;
  logic [3:0][COEF_W-1:0] r_c;
  logic signed [ACC_W-1:0] r_acc;
  logic [DATA_W-1:0]       r_out_data;
  logic                    r_out_valid;

  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W:0]    w_rnd;
  logic signed [ACC_W:0]    w_shr;
  logic [DATA_W-1:0]        w_sat;

  assign w_prod = $signed(r_x[mux_sel]) * $signed(r_c[mux_sel]);
  assign w_sum  = r_acc + {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
  // One guard bit so the rounding add cannot wrap
  assign w_rnd  = {w_sum[ACC_W-1], w_sum} + RND_HALF;
  assign w_shr  = w_rnd >>> (COEF_W-1);

  always_comb begin
    w_sat = w_shr[DATA_W-1:0];
    if (w_shr > SAT_HI)      w_sat = {1'b0, {(DATA_W-1){1'b1}}};
    else if (w_shr < SAT_LO) w_sat = {1'b1, {(DATA_W-1){1'b0}}};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x         <= '0;
      r_c         <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_acc       <= clear_accum ? '0 : w_sum;
      r_out_valid <= data_clk;
      if (data_clk) begin
        r_out_data <= w_sat;
        r_x        <= {r_x[2:0], sample_in};
      end
      if (coef_we) r_c[coef_addr] <= coef_data;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;

endmodule
